// File: rtl/riscv_pkg.sv
// Shared RV64 decode constants: opcodes, branch funct3 codes and immediate formats.
// Helper functions classify an opcode by immediate format and legality.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

  // R-type opcodes carry no immediate but are still supported.
  function automatic logic opcode_legal(input logic [6:0] op);
    return (imm_fmt(op) != IMM_NONE) || (op == OP_OP) || (op == OP_OP32);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports with write-first bypass,
// one write port, x0 hardwired to zero, single-cycle synchronous clear.
module reg_file #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_hit;

  assign wr_hit = wb_en && (wb_rd != 5'd0) && (int'(wb_rd) < NREGS);

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0 || int'(addr) >= NREGS) return '0;
    if (wr_hit && wb_rd == addr)             return wb_data;
    return regs[addr];
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

  // NOTE: clearing every entry in one cycle keeps this a flop array; it cannot
  // map onto a RAM macro, which has no single-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: register read, immediate generation, branch resolution and the
// ID/EX pipeline register with reset > flush > stall > load priority.
module id_stage #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [6:0]      opcode,
  output logic            funct7_b5,
  output logic            branch_taken,
  output logic            illegal
);
  import riscv_pkg::*;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      opcode;
    logic            funct7_b5;
    logic            branch_taken;
    logic            illegal;
  } idex_t;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [XLEN-1:0] rf_rs1, rf_rs2, imm_w;
  logic            taken_w;
  idex_t           idex_d, idex_q;

  assign op = instruction[6:0];
  assign f3 = instruction[14:12];

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (instruction[19:15]),
    .rs2_addr (instruction[24:20]),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    imm_w = '0;
    case (imm_fmt(op))
      IMM_I: imm_w = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
      IMM_S: imm_w = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B: imm_w = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      IMM_U: imm_w = {{(XLEN-32){instruction[31]}}, instruction[31:12], 12'b0};
      IMM_J: imm_w = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      default: imm_w = '0;
    endcase
  end

  // Compare uses the bypassed operands so a same-cycle write-back is seen.
  always_comb begin
    taken_w = 1'b0;
    if (op == OP_BRANCH) begin
      case (f3)
        F3_BEQ:  taken_w = (rf_rs1 == rf_rs2);
        F3_BNE:  taken_w = (rf_rs1 != rf_rs2);
        default: taken_w = 1'b0;
      endcase
    end else if (op == OP_JAL) begin
      taken_w = 1'b1;
    end
  end

  always_comb begin
    idex_d              = '0;
    idex_d.valid        = 1'b1;
    idex_d.pc           = pc;
    idex_d.rs1          = rf_rs1;
    idex_d.rs2          = rf_rs2;
    idex_d.imm          = imm_w;
    idex_d.rd           = instruction[11:7];
    idex_d.funct3       = f3;
    idex_d.opcode       = op;
    idex_d.funct7_b5    = instruction[30];
    idex_d.branch_taken = taken_w;
    idex_d.illegal      = !opcode_legal(op);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      idex_q <= '0;
    end else if (!stall) begin
      idex_q <= idex_d;
    end
  end

  assign valid_out    = idex_q.valid;
  assign pc_out       = idex_q.pc;
  assign rs1_data     = idex_q.rs1;
  assign rs2_data     = idex_q.rs2;
  assign imm          = idex_q.imm;
  assign rd           = idex_q.rd;
  assign funct3       = idex_q.funct3;
  assign opcode       = idex_q.opcode;
  assign funct7_b5    = idex_q.funct7_b5;
  assign branch_taken = idex_q.branch_taken;
  assign illegal      = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the register file and ID/EX register.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, wb_en;
  logic [31:0] instruction;
  logic [63:0] pc, wb_data;
  logic [4:0]  wb_rd;

  logic        valid_out, funct7_b5, branch_taken, illegal;
  logic [63:0] pc_out, rs1_data, rs2_data, imm;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  opcode;

  always #5 clk = ~clk;

  id_stage #(.XLEN(64), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .pc(pc),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .valid_out(valid_out), .pc_out(pc_out), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .rd(rd), .funct3(funct3), .opcode(opcode), .funct7_b5(funct7_b5),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic        f7;
    logic        bt;
    logic        ill;
  } exp_t;

  exp_t        exp_q;
  logic [63:0] mregs [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Interpret the low 'bits' of v as a two's-complement number.
  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] mask;
    logic [63:0] val;
    mask = (64'd1 << bits) - 64'd1;
    val  = v & mask;
    if (val[bits-1]) return val | ~mask;
    return val;
  endfunction

  function automatic logic [63:0] model_imm(input logic [31:0] ins);
    logic [63:0] w;
    w = {32'd0, ins};
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: return sx(w >> 20, 12);
      7'h23: return sx(((w >> 25) << 5) | ((w >> 7) & 64'd31), 12);
      7'h63: return sx(((w >> 31) << 12) | (((w >> 7) & 64'd1) << 11) |
                       (((w >> 25) & 64'd63) << 5) | (((w >> 8) & 64'd15) << 1), 13);
      7'h37, 7'h17: return sx(w & 64'hFFFF_F000, 32);
      7'h6F: return sx(((w >> 31) << 20) | (((w >> 12) & 64'd255) << 12) |
                       (((w >> 20) & 64'd1) << 11) | (((w >> 21) & 64'd1023) << 1), 21);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return mregs[a];
  endfunction

  task automatic compare_all();
    check("valid_out",    64'(valid_out),    64'(exp_q.valid));
    check("pc_out",       pc_out,            exp_q.pc);
    check("rs1_data",     rs1_data,          exp_q.rs1);
    check("rs2_data",     rs2_data,          exp_q.rs2);
    check("imm",          imm,               exp_q.imm);
    check("rd",           64'(rd),           64'(exp_q.rd));
    check("funct3",       64'(funct3),       64'(exp_q.f3));
    check("opcode",       64'(opcode),       64'(exp_q.op));
    check("funct7_b5",    64'(funct7_b5),    64'(exp_q.f7));
    check("branch_taken", 64'(branch_taken), 64'(exp_q.bt));
    check("illegal",      64'(illegal),      64'(exp_q.ill));
  endtask

  // Drive one cycle of inputs, update the model, clock, then compare everything.
  task automatic step(input logic rst, input logic st, input logic fl, input logic we,
                      input logic [4:0] wr, input logic [63:0] wd,
                      input logic [31:0] ins, input logic [63:0] p);
    logic [6:0] op;
    logic [2:0] f3;
    reset = rst; stall = st; flush = fl; wb_en = we; wb_rd = wr; wb_data = wd;
    instruction = ins; pc = p;
    op = ins[6:0];
    f3 = ins[14:12];
    if (rst || fl) begin
      exp_q = '{default: '0};
    end else if (!st) begin
      exp_q.valid = 1'b1;
      exp_q.pc    = p;
      exp_q.rs1   = model_read(ins[19:15]);
      exp_q.rs2   = model_read(ins[24:20]);
      exp_q.imm   = model_imm(ins);
      exp_q.rd    = ins[11:7];
      exp_q.f3    = f3;
      exp_q.op    = op;
      exp_q.f7    = ins[30];
      exp_q.bt    = (op == 7'h63 && f3 == 3'd0 && exp_q.rs1 == exp_q.rs2) ||
                    (op == 7'h63 && f3 == 3'd1 && exp_q.rs1 != exp_q.rs2) ||
                    (op == 7'h6F);
      exp_q.ill   = !(op inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h33, 7'h3B});
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    end else if (we && wr != 5'd0) begin
      mregs[wr] = wd;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic load(input logic [31:0] ins, input logic [63:0] p);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, ins, p);
  endtask

  logic [6:0] op_pool [12];

  initial begin
    logic [63:0] held_imm, held_rs1;
    logic [31:0] ins;
    logic [4:0]  r1;
    op_pool = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h63, 7'h37, 7'h17,
                7'h6F, 7'h33, 7'h3B, 7'h00};
    exp_q = '{default: '0};
    for (int i = 0; i < 32; i++) mregs[i] = 64'hX;

    // Reset while a write-back is pending: outputs and registers clear.
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 64'hDEAD, 32'h00528313, 64'h40);
    check("reset_valid", 64'(valid_out), 64'd0);
    load(32'h00018093, 64'h44);                 // addi x1,x3,0
    check("reset_blocks_write", rs1_data, 64'd0);

    // Write x5, then addi x6,x5,5.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h1234, 32'h00000013, 64'h100);
    load(32'h00528313, 64'h104);
    check("addi_rs1", rs1_data, 64'h1234);
    check("addi_imm", imm, 64'd5);
    check("addi_rd", 64'(rd), 64'd6);
    check("addi_illegal", 64'(illegal), 64'd0);

    // Same-cycle write-back bypass into a beq.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 64'hAA, 32'h00108463, 64'h108);
    check("bypass_rs1", rs1_data, 64'hAA);
    check("bypass_rs2", rs2_data, 64'hAA);
    check("bypass_imm", imm, 64'd8);
    check("bypass_taken", 64'(branch_taken), 64'd1);

    // Writes to x0 are discarded.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 64'hFFFF, 32'h00000013, 64'h10C);
    load(32'h00000313, 64'h110);
    check("x0_read", rs1_data, 64'd0);

    // Backward beq, stall with changing inputs, then flush over stall.
    load(32'hFE000EE3, 64'h200);
    check("neg_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("neg_taken", 64'(branch_taken), 64'd1);
    held_imm = imm;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 5'(i + 7), 64'(i * 3 + 1), $urandom, 64'(i * 4));
      check("stall_hold_imm", imm, held_imm);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 32'h00528313, 64'h300);
    check("flush_valid", 64'(valid_out), 64'd0);
    check("flush_taken", 64'(branch_taken), 64'd0);

    // Reset in the middle of a stall stays zero until the next real load.
    load(32'h00528313, 64'h400);
    held_rs1 = rs1_data;
    check("pre_reset_rs1", held_rs1, 64'h1234);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 32'h00108463, 64'h404);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 64'h55, 32'h00108463, 64'h408);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 32'h00108463, 64'h40C);
    check("reset_stall_valid", 64'(valid_out), 64'd0);
    load(32'h00000000, 64'h410);
    check("zero_illegal", 64'(illegal), 64'd1);
    check("zero_valid", 64'(valid_out), 64'd1);
    for (int i = 1; i < 32; i++) begin
      load({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33}, 64'(i));
      check("cleared_reg", rs1_data, 64'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:0] = op_pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0) ins[6:0] = 7'($urandom);
      if ($urandom_range(0, 1) == 0) ins[14:12] = 3'($urandom_range(0, 1));
      r1 = 5'($urandom_range(0, 7));
      ins[19:15] = r1;
      ins[24:20] = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 7));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 64'(r1) : {$urandom, $urandom},
           ins, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: XLEN, default 64, datapath width of PC, immediates and register data.
REQ-002 Parameter: NREGS, default 32, number of architectural integer registers.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instruction  input  32  fetched instruction from the IF stage.
REQ-006 pc  input  XLEN  address of that instruction from the IF stage.
REQ-007 stall  input  1  hold all ID/EX output registers.
REQ-008 flush  input  1  replace the next ID/EX contents with a bubble.
REQ-009 wb_en  input  1  write-back enable.
REQ-010 wb_rd  input  5  write-back destination register.
REQ-011 wb_data  input  XLEN  write-back data.
REQ-012 valid_out  output  1  ID/EX register holds a real instruction.
REQ-013 pc_out  output  XLEN  registered PC.
REQ-014 rs1_data, rs2_data  output  XLEN each  registered source operands.
REQ-015 imm  output  XLEN  registered sign-extended immediate; also drives IF immediate.
REQ-016 rd, funct3, opcode  output  5/3/7  registered instruction fields.
REQ-017 funct7_b5  output  1  registered instruction bit 30.
REQ-018 branch_taken  output  1  registered; drives IF mux_control.
REQ-019 illegal  output  1  registered; opcode not in the supported set.

Function
REQ-020 The ID/EX register SHALL have 1-cycle latency: inputs sampled at edge N appear on the outputs after edge N.
REQ-021 Priority SHALL be reset > flush > stall > normal load.
REQ-022 Flush SHALL load a bubble: valid_out=0, rd=0, branch_taken=0, illegal=0, all other outputs 0.
REQ-023 Stall without flush SHALL hold every ID/EX output unchanged.
REQ-024 Register x0 SHALL read 0 at all times; writes to x0 SHALL be ignored.
REQ-025 A write SHALL occur at the clock edge when wb_en=1 and wb_rd!=0, regardless of stall or flush.
REQ-026 Reads SHALL be combinational with write-first bypass: when wb_en=1 and wb_rd equals rs1/rs2 (and is nonzero), the read returns wb_data in the same cycle.
REQ-027 Immediate SHALL be sign-extended from instruction[31] to XLEN, with the format selected by opcode:
- I: 0000011, 0010011, 1100111
- S: 0100011
- B: 1100011, bit0=0
- U: 0110111, 0010111, low 12 bits 0
- J: 1101111, bit0=0
- all others: 0
REQ-028 branch_taken SHALL be 1 in each of these cases:
- opcode 1100011, funct3 000, operands equal
- opcode 1100011, funct3 001, operands unequal
- opcode 1101111
It SHALL be 0 in all other cases. Operand comparison SHALL use the bypassed read values.
REQ-029 illegal SHALL be 1 when the opcode is outside the REQ-027 list plus 0110011 and 0111011; for such an opcode valid_out SHALL still be 1.
REQ-030 Loading an all-zero instruction SHALL produce illegal=1.

Reset
REQ-031 Reset SHALL clear every ID/EX output to 0, including valid_out, branch_taken and illegal.
REQ-032 Reset SHALL clear all NREGS registers to 0 in one cycle.
REQ-033 Reset SHALL override any concurrent stall, flush or wb_en; no write occurs in that cycle.
REQ-034 Reset asserted mid-stall SHALL leave outputs at 0 after release until the next non-stalled load.

Structure
REQ-035 Package riscv_pkg SHALL hold XLEN, the opcode constants, the funct3 branch constants and an immediate-format enum.
REQ-036 The register file SHALL be a sub-module named reg_file (2 read ports, 1 write port, bypass, x0 rule, sync clear).
REQ-037 Decode, immediate generation and the branch compare SHALL be combinational logic feeding the ID/EX register inside id_stage.

Verification
REQ-038 Write x5=0x1234 via wb; next cycle instruction 0x00528313 (addi x6,x5,5) -> rs1_data=0x1234, imm=5, rd=6, valid_out=1, illegal=0.
REQ-039 Same-cycle wb_en=1, wb_rd=1, wb_data=0xAA with instruction 0x00108463 (beq x1,x1,8) -> rs1_data=rs2_data=0xAA, imm=8, branch_taken=1.
REQ-040 Write wb_rd=0 with 0xFFFF, then read x0 -> rs1_data=0.
REQ-041 Instruction 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFFFFFFFFFC, branch_taken=1; stall=1 for 3 cycles with changing input -> outputs unchanged; flush=1 with stall=1 -> valid_out=0, branch_taken=0.
REQ-042 Reset asserted while wb_en=1 -> all outputs 0 and all registers 0 afterwards; instruction 0x00000000 -> illegal=1, valid_out=1.
